// File: rtl/mips_alu_pkg.sv
// Shared types and constants for the MIPS ALU/divider datapath.
package mips_alu_pkg;

  localparam int DIV_WIDTH = 32;

  // Declared signed so a size cast to any WIDTH stays all-ones.
  localparam logic signed [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract,
// keep the difference or restore.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, divisor};
    // The top bit of the trial difference is the borrow.
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU (quotient -> LO, remainder -> HI).
// Define DIV_EARLY_EXIT_EN to finish in two cycles when |dividend| < |divisor|.
module div_seq
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZERO_Q = WIDTH'(DIV_ZERO_QUOTIENT);

  div_state_e state_reg, state_next;

  logic [WIDTH-1:0] dvd_reg, dvs_reg, mag_dvs_reg;
  logic [WIDTH-1:0] quo_reg, rem_reg;
  logic [WIDTH-1:0] quotient_reg, remainder_reg;
  logic             sgn_reg, q_neg_reg, r_neg_reg, dbz_reg, dbz_out_reg;
  logic [CW-1:0]    count_reg;

  logic             dvd_neg, dvs_neg, dvs_zero, early;
  logic [WIDTH-1:0] mag_dvd, mag_dvs, fix_q, fix_r, step_rem;
  logic             step_q;

  assign dvd_neg  = sgn_reg & dvd_reg[WIDTH-1];
  assign dvs_neg  = sgn_reg & dvs_reg[WIDTH-1];
  assign mag_dvd  = dvd_neg ? -dvd_reg : dvd_reg;
  assign mag_dvs  = dvs_neg ? -dvs_reg : dvs_reg;
  assign dvs_zero = (dvs_reg == '0);

`ifdef DIV_EARLY_EXIT_EN
  assign early = (mag_dvd < mag_dvs);
`else
  assign early = 1'b0;
`endif

  assign fix_q = q_neg_reg ? -quo_reg : quo_reg;
  assign fix_r = r_neg_reg ? -rem_reg : rem_reg;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_reg),
    .bit_in  (quo_reg[WIDTH-1]),
    .divisor (mag_dvs_reg),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Short-cut results also pass through FIX (with no negation pending) so the
  // divide-by-zero and early-exit paths both land in DONE two edges after start.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = PREP;
      PREP: state_next = (dvs_zero || early) ? FIX : ITER;
      ITER: if (count_reg == LAST_STEP) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_reg       <= '0;
      dvs_reg       <= '0;
      mag_dvs_reg   <= '0;
      quo_reg       <= '0;
      rem_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      sgn_reg       <= 1'b0;
      q_neg_reg     <= 1'b0;
      r_neg_reg     <= 1'b0;
      dbz_reg       <= 1'b0;
      dbz_out_reg   <= 1'b0;
      count_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            dvd_reg <= dividend;
            dvs_reg <= divisor;
            sgn_reg <= signed_op;
          end
        end
        PREP: begin
          count_reg <= '0;
          dbz_reg   <= dvs_zero;
          if (dvs_zero) begin
            quo_reg   <= ZERO_Q;
            rem_reg   <= dvd_reg;
            q_neg_reg <= 1'b0;
            r_neg_reg <= 1'b0;
          end else if (early) begin
            quo_reg   <= '0;
            rem_reg   <= dvd_reg;
            q_neg_reg <= 1'b0;
            r_neg_reg <= 1'b0;
          end else begin
            quo_reg     <= mag_dvd;
            rem_reg     <= '0;
            mag_dvs_reg <= mag_dvs;
            q_neg_reg   <= dvd_neg ^ dvs_neg;
            r_neg_reg   <= dvd_neg;
          end
        end
        ITER: begin
          // quo_reg shifts dividend bits out the top and quotient bits in the bottom.
          rem_reg   <= step_rem;
          quo_reg   <= {quo_reg[WIDTH-2:0], step_q};
          count_reg <= count_reg + 1'b1;
        end
        FIX: begin
          quotient_reg  <= fix_q;
          remainder_reg <= fix_r;
          dbz_out_reg   <= dbz_reg;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_reg == ITER) || (state_reg == FIX) || (state_reg == DONE);
  assign done        = (state_reg == DONE);
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_out_reg;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq (default WIDTH=32).
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

`ifdef DIV_EARLY_EXIT_EN
  localparam int EARLY_LAT = 2;
`else
  localparam int EARLY_LAT = 34;
`endif

  div_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Issue one divide and wait for done; lat counts edges after the accepting edge.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r, output logic dz,
                         output int lat, output int busy_bad);
    @(negedge clk);
    dividend = a; divisor = b; signed_op = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_bad = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (!busy) busy_bad++;
    end
    q = quotient; r = remainder; dz = div_by_zero;
    $display("div a=%h b=%h signed=%0d -> q=%h r=%h dbz=%0d lat=%0d", a, b, s, q, r, dz, lat);
  endtask

  task automatic check_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [31:0] eq, input logic [31:0] er,
                           input logic edz, input int elat);
    logic [31:0] q, r;
    logic dz;
    int lat, bb;
    run_div(a, b, s, q, r, dz, lat, bb);
    checks++; if (q !== eq) begin errors++; $display("FAIL %s quotient: got %h expected %h", name, q, eq); end
    checks++; if (r !== er) begin errors++; $display("FAIL %s remainder: got %h expected %h", name, r, er); end
    checks++; if (dz !== edz) begin errors++; $display("FAIL %s div_by_zero: got %0d expected %0d", name, dz, edz); end
    checks++; if (lat != elat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, elat); end
    checks++; if (bb != 0) begin errors++; $display("FAIL %s busy: got %0d low cycles expected 0", name, bb); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done_pulse: got %b expected 0", name, done); end
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 67'd0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b dbz=%b q=%h r=%h expected all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, quotient} !== 34'd0) begin
      errors++;
      $display("FAIL reset_release: got busy=%b done=%b q=%h expected 0", busy, done, quotient);
    end
  endtask

  task automatic test_unsigned;
    check_div("udiv_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34);
    check_div("udiv_big", 32'hFFFF_FFFF, 32'd16, 1'b0, 32'h0FFF_FFFF, 32'd15, 1'b0, 34);
    check_div("udiv_neg_as_unsigned", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 34);
  endtask

  task automatic test_signed;
    check_div("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34);
    check_div("sdiv_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 34);
    check_div("sdiv_m7_m2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3, 32'hFFFF_FFFF, 1'b0, 34);
    check_div("sdiv_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 34);
  endtask

  task automatic test_div_zero;
    check_div("sdiv_5_0", 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1, 2);
    check_div("udiv_5_0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 2);
    check_div("sdiv_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 2);
    // dbz must drop on the next normal result
    check_div("after_zero", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 34);
  endtask

  task automatic test_early_exit;
    check_div("udiv_3_9", 32'd3, 32'd9, 1'b0, 32'd0, 32'd3, 1'b0, EARLY_LAT);
    check_div("sdiv_m3_9", 32'hFFFF_FFFD, 32'd9, 1'b1, 32'd0, 32'hFFFF_FFFD, 1'b0, EARLY_LAT);
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; signed_op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 10) begin
        dividend = 32'd50; divisor = 32'd5; signed_op = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    $display("b2b first: q=%h r=%h lat=%0d", quotient, remainder, lat);
    checks++; if (lat != 34) begin errors++; $display("FAIL b2b_latency: got %0d expected 34", lat); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL b2b_quotient: got %h expected %h", quotient, 32'd14); end
    checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL b2b_remainder: got %h expected %h", remainder, 32'd2); end
    // start held from the done cycle into the next: only the second edge accepts it
    dividend = 32'd9; divisor = 32'd2; signed_op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_done_start_ignored: got busy=%b expected 0", busy); end
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("b2b second: q=%h r=%h lat=%0d", quotient, remainder, lat);
    checks++; if (lat != 34) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 34", lat); end
    checks++; if (quotient !== 32'd4) begin errors++; $display("FAIL b2b_second_quotient: got %h expected %h", quotient, 32'd4); end
    checks++; if (remainder !== 32'd1) begin errors++; $display("FAIL b2b_second_remainder: got %h expected %h", remainder, 32'd1); end
  endtask

  task automatic test_reset_mid;
    int seen_done;
    @(negedge clk);
    dividend = 32'd1000; divisor = 32'd3; signed_op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    $display("reset mid-op: busy=%b done=%b q=%h r=%h", busy, done, quotient, remainder);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    checks++;
    if ({done, div_by_zero, quotient, remainder} !== 66'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got done=%b q=%h r=%h expected 0", done, quotient, remainder);
    end
    @(negedge clk); rst_n = 1'b1;
    seen_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen_done++;
    end
    checks++; if (seen_done != 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d active cycles expected 0", seen_done); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_early_exit();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
